pipeline_stage_ctrl: RTL and testbench
======================================

// Module: pipeline_stage_ctrl
// PURPOSE
// - Consumer side of the hazard/forwarding interface. Turns hazard requests into per-latch enable/flush
//   and PC enable for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Requests handled: load-use stall, EX-resolved branch/jump squash, I-fetch miss, D-mem wait, halt drain.
// - Keeps saturating event counters for performance debug, plus a D-mem wait watchdog.
// PARAMETERS
// - CNT_W       32   width of each event counter
// - WAIT_LIMIT  255  consecutive MEM_WAIT cycles before mem_timeout sets
// PORTS
// - CLK            in   1      clock; all state updates on the rising edge
// - RST            in   1      synchronous, active-high reset
// - StallLW        in   1      load-use stall request from the hazard unit
// - branch_taken   in   1      taken branch/jump resolved in EX; PC loads the target
// - ihit           in   1      instruction fetch completed this cycle
// - EXMEM_dREN     in   1      data read pending in MEM
// - EXMEM_dWEN     in   1      data write pending in MEM
// - dhit           in   1      data access completed this cycle
// - EXMEM_halt     in   1      halt instruction is in MEM
// - pc_en          out  1      PC update enable
// - IFID_en, IDEX_en, EXMEM_en, MEMWB_en  out  1 each  latch enables
// - IFID_flush, IDEX_flush                out  1 each  load bubble (NOP) into the latch at this edge
// - halt           out  1      registered; sticky until RST
// - mem_timeout    out  1      registered; sticky until RST
// - cnt_lw, cnt_flush, cnt_memwait        out  CNT_W each  saturating event counters
// BEHAVIOUR
// - Reset: while RST=1, the following hold:
//   - state=RUN; halt=0; mem_timeout=0; all counters=0
//   - all _en=0; pc_en=0; IFID_flush=IDEX_flush=1
// - Outputs are combinational from state and inputs. Default (RUN, no request): every en=1, every flush=0.
// - States: RUN, MEM_WAIT, DRAIN, HALTED.
// - Priority in RUN, highest first:
//   1. D-access miss: (EXMEM_dREN|EXMEM_dWEN) & !dhit
//      - all en=0, pc_en=0; next state MEM_WAIT; cnt_memwait++
//   2. EXMEM_halt
//      - pc_en=0; IFID_flush=IDEX_flush=1; EXMEM_en=MEMWB_en=1; next state DRAIN
//   3. branch_taken
//      - pc_en=1; IFID_flush=IDEX_flush=1; cnt_flush++
//      - StallLW in the same cycle is ignored and not counted
//   4. StallLW
//      - pc_en=0; IFID_en=0; IDEX_flush=1; EXMEM/MEMWB advance; cnt_lw++
//   5. !ihit
//      - pc_en=0; IFID_flush=1; downstream latches advance
// - MEM_WAIT:
//   - While dhit=0: everything frozen (all en=0, flushes 0); cnt_memwait++ every cycle.
//   - On dhit=1: RUN-default outputs this cycle (all latches advance); next state RUN.
//   - Branch/StallLW seen on the dhit cycle is re-evaluated next cycle from the re-presented inputs;
//     it is never lost and never double-counted.
//   - Wait counter reaches WAIT_LIMIT -> mem_timeout sets; the block keeps waiting (no abort).
// - DRAIN: one cycle.
//   - MEMWB_en=1; all others 0; IDEX_flush=1; next state HALTED.
// - HALTED:
//   - all en=0; pc_en=0; halt=1 from the first HALTED edge on; all inputs ignored.
// - Counters:
//   - saturate at all-ones (no wrap)
//   - freeze in HALTED
//   - wait counter clears on MEM_WAIT exit
// - RST mid-operation: any state, including mid MEM_WAIT, returns to RUN next edge; sticky flags clear.
// STRUCTURE
// - cpu_types_pkg:
//   - typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} pipe_state_t
//   - WAIT_LIMIT default constant
// - Sub-module sat_counter #(W): en, clr, q; saturating. Instantiated 4x (3 event counters + wait counter).
// - One always_ff for state and sticky flags; one always_comb for the enable/flush decode.
// TESTING
// - Reset: RST=1 for 2 cycles -> all en=0, IFID_flush=IDEX_flush=1, counters 0; after release with
//   ihit=1 and no requests -> all en=1, pc_en=1.
// - StallLW=1 one cycle, ihit=1 -> pc_en=0, IFID_en=0, IDEX_flush=1, EXMEM_en=1; cnt_lw=1.
// - StallLW=1 and branch_taken=1 together -> pc_en=1, IFID_flush=IDEX_flush=1; cnt_flush=1, cnt_lw=0.
// - EXMEM_dREN=1, dhit=0 for 4 cycles then dhit=1 -> 4 frozen cycles, then all en=1, state RUN; cnt_memwait=4.
// - WAIT_LIMIT=3, dhit held 0 -> mem_timeout=1 after 3 wait cycles; then dhit=1 -> RUN, mem_timeout stays 1.
// - EXMEM_halt=1 -> DRAIN (MEMWB_en=1 only) -> HALTED, halt=1; toggling StallLW/branch has no effect;
//   RST=1 -> halt=0, state RUN.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and defaults for the pipeline stage controller.
package cpu_types_pkg;

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} pipe_state_t;

    localparam int unsigned WAIT_LIMIT_DEFAULT = 255;
    localparam int unsigned CNT_W_DEFAULT      = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// Turns hazard requests into latch enable/flush and PC enable for a 5-stage pipeline,
// with saturating event counters and a D-mem wait watchdog.
module pipeline_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEFAULT,
    parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             StallLW,
    input  logic             branch_taken,
    input  logic             ihit,
    input  logic             EXMEM_dREN,
    input  logic             EXMEM_dWEN,
    input  logic             dhit,
    input  logic             EXMEM_halt,
    output logic             pc_en,
    output logic             IFID_en,
    output logic             IDEX_en,
    output logic             EXMEM_en,
    output logic             MEMWB_en,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             halt,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cnt_lw,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_memwait
);

    localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);

    pipe_state_t       state, state_next;
    logic              d_miss;
    logic              inc_lw, inc_flush, inc_wait, wait_clr;
    logic [WAIT_W-1:0] wait_cnt;

    assign d_miss = (EXMEM_dREN | EXMEM_dWEN) & ~dhit;

    always_comb begin
        state_next = state;
        pc_en      = 1'b1;
        IFID_en    = 1'b1;
        IDEX_en    = 1'b1;
        EXMEM_en   = 1'b1;
        MEMWB_en   = 1'b1;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        inc_lw     = 1'b0;
        inc_flush  = 1'b0;
        inc_wait   = 1'b0;
        wait_clr   = 1'b0;

        unique case (state)
            RUN: begin
                if (d_miss) begin
                    {pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '0;
                    state_next = MEM_WAIT;
                    inc_wait   = 1'b1;
                end else if (EXMEM_halt) begin
                    pc_en      = 1'b0;
                    IFID_flush = 1'b1;
                    IDEX_flush = 1'b1;
                    state_next = DRAIN;
                end else if (branch_taken) begin
                    // A load-use stall in the same cycle is moot: its consumer is squashed.
                    IFID_flush = 1'b1;
                    IDEX_flush = 1'b1;
                    inc_flush  = 1'b1;
                end else if (StallLW) begin
                    pc_en      = 1'b0;
                    IFID_en    = 1'b0;
                    IDEX_flush = 1'b1;
                    inc_lw     = 1'b1;
                end else if (!ihit) begin
                    pc_en      = 1'b0;
                    IFID_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dhit) begin
                    {pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '0;
                    inc_wait = 1'b1;
                end else begin
                    // Other requests on the release cycle are picked up again from RUN.
                    state_next = RUN;
                    wait_clr   = 1'b1;
                end
            end
            DRAIN: begin
                {pc_en, IFID_en, IDEX_en, EXMEM_en} = '0;
                IDEX_flush = 1'b1;
                state_next = HALTED;
            end
            HALTED: begin
                {pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '0;
            end
            default: state_next = RUN;
        endcase

        if (RST) begin
            {pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '0;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            state_next = RUN;
            inc_lw     = 1'b0;
            inc_flush  = 1'b0;
            inc_wait   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            halt        <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DRAIN) begin
                halt <= 1'b1;
            end
            // Set on the same edge the wait counter reaches the limit.
            if (inc_wait && (wait_cnt >= WAIT_W'(WAIT_LIMIT - 1))) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_lw (
        .clk (CLK),
        .en  (inc_lw),
        .clr (RST),
        .q   (cnt_lw)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk (CLK),
        .en  (inc_flush),
        .clr (RST),
        .q   (cnt_flush)
    );

    sat_counter #(.W(CNT_W)) u_cnt_memwait (
        .clk (CLK),
        .en  (inc_wait),
        .clr (RST),
        .q   (cnt_memwait)
    );

    sat_counter #(.W(WAIT_W)) u_cnt_wait (
        .clk (CLK),
        .en  (inc_wait),
        .clr (RST | wait_clr),
        .q   (wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Directed-vector bench for pipeline_stage_ctrl; driver queues expectations, monitor checks them.
module tb_pipeline_stage_ctrl;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned WAIT_LIMIT = 3;
    localparam int X = -1;

    // Input bits: {RST, StallLW, branch_taken, ihit, dREN, dWEN, dhit, EXMEM_halt}
    localparam logic [7:0] I_RST  = 8'h80;
    localparam logic [7:0] I_LW   = 8'h40;
    localparam logic [7:0] I_BR   = 8'h20;
    localparam logic [7:0] I_IHIT = 8'h10;
    localparam logic [7:0] I_DREN = 8'h08;
    localparam logic [7:0] I_DWEN = 8'h04;
    localparam logic [7:0] I_DHIT = 8'h02;
    localparam logic [7:0] I_HALT = 8'h01;

    logic             CLK, RST, StallLW, branch_taken, ihit;
    logic             EXMEM_dREN, EXMEM_dWEN, dhit, EXMEM_halt;
    logic             pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
    logic             IFID_flush, IDEX_flush, halt, mem_timeout;
    logic [CNT_W-1:0] cnt_lw, cnt_flush, cnt_memwait;

    typedef struct {
        int         id;
        logic [4:0] en;
        logic [1:0] fl;
        int         hl, mt, lw, fc, mw;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   vec_id = 0;

    pipeline_stage_ctrl #(
        .CNT_W      (CNT_W),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .StallLW      (StallLW),
        .branch_taken (branch_taken),
        .ihit         (ihit),
        .EXMEM_dREN   (EXMEM_dREN),
        .EXMEM_dWEN   (EXMEM_dWEN),
        .dhit         (dhit),
        .EXMEM_halt   (EXMEM_halt),
        .pc_en        (pc_en),
        .IFID_en      (IFID_en),
        .IDEX_en      (IDEX_en),
        .EXMEM_en     (EXMEM_en),
        .MEMWB_en     (MEMWB_en),
        .IFID_flush   (IFID_flush),
        .IDEX_flush   (IDEX_flush),
        .halt         (halt),
        .mem_timeout  (mem_timeout),
        .cnt_lw       (cnt_lw),
        .cnt_flush    (cnt_flush),
        .cnt_memwait  (cnt_memwait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic chk_bit(input logic act, input int want);
        return (want < 0) || (act === want[0]);
    endfunction

    function automatic logic chk_cnt(input logic [CNT_W-1:0] act, input int want);
        return (want < 0) || (act === CNT_W'(want));
    endfunction

    // Monitor: outputs are combinational, so every queued cycle is checked mid-cycle.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (!(({pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} === e.en) &&
                  ({IFID_flush, IDEX_flush} === e.fl) &&
                  chk_bit(halt, e.hl) && chk_bit(mem_timeout, e.mt) &&
                  chk_cnt(cnt_lw, e.lw) && chk_cnt(cnt_flush, e.fc) &&
                  chk_cnt(cnt_memwait, e.mw))) begin
                fails++;
                $display("FAIL vec%0d: got en=%b fl=%b halt=%b mto=%b lw=%0d fc=%0d mw=%0d | want en=%b fl=%b halt=%0d mto=%0d lw=%0d fc=%0d mw=%0d",
                         e.id, {pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en},
                         {IFID_flush, IDEX_flush}, halt, mem_timeout, cnt_lw, cnt_flush,
                         cnt_memwait, e.en, e.fl, e.hl, e.mt, e.lw, e.fc, e.mw);
            end
        end
    end

    task automatic v(input logic [7:0] in, input logic [4:0] en, input logic [1:0] fl,
                     input int hl, input int mt, input int lw, input int fc, input int mw);
        exp_t x;
        @(posedge CLK);
        #1;
        {RST, StallLW, branch_taken, ihit, EXMEM_dREN, EXMEM_dWEN, dhit, EXMEM_halt} = in;
        x.id = vec_id; x.en = en; x.fl = fl;
        x.hl = hl; x.mt = mt; x.lw = lw; x.fc = fc; x.mw = mw;
        exp_q.push_back(x);
        vec_id++;
    endtask

    initial begin
        {RST, StallLW, branch_taken, ihit, EXMEM_dREN, EXMEM_dWEN, dhit, EXMEM_halt} = I_RST;

        // Reset and idle run; en order {pc, IFID, IDEX, EXMEM, MEMWB}, fl {IFID, IDEX}
        v(I_RST,  5'b00000, 2'b11, X, X, X, X, X);
        v(I_RST,  5'b00000, 2'b11, 0, 0, 0, 0, 0);
        v(I_IHIT, 5'b11111, 2'b00, 0, 0, 0, 0, 0);
        // Load-use stall
        v(I_LW | I_IHIT, 5'b00111, 2'b01, 0, 0, 0, 0, 0);
        v(I_IHIT,        5'b11111, 2'b00, 0, 0, 1, 0, 0);
        // Branch beats stall; stall not counted
        v(I_LW | I_BR | I_IHIT, 5'b11111, 2'b11, 0, 0, 1, 0, 0);
        v(I_IHIT,               5'b11111, 2'b00, 0, 0, 1, 1, 0);
        // Fetch miss, then branch during fetch miss
        v(8'h00,         5'b01111, 2'b10, 0, 0, 1, 1, 0);
        v(I_BR,          5'b11111, 2'b11, 0, 0, 1, 1, 0);
        v(I_IHIT,        5'b11111, 2'b00, 0, 0, 1, 2, 0);
        // Four D-read wait cycles; watchdog trips after the third
        v(I_RST,           5'b00000, 2'b11, 0, 0, 1, 2, 0);
        v(I_DREN | I_IHIT, 5'b00000, 2'b00, 0, 0, 0, 0, 0);
        v(I_DREN | I_IHIT, 5'b00000, 2'b00, 0, 0, 0, 0, 1);
        v(I_DREN | I_IHIT, 5'b00000, 2'b00, 0, 0, 0, 0, 2);
        v(I_DREN | I_IHIT, 5'b00000, 2'b00, 0, 1, 0, 0, 3);
        // Release cycle ignores branch/stall; they are re-evaluated next cycle, counted once
        v(I_DREN | I_DHIT | I_LW | I_BR | I_IHIT, 5'b11111, 2'b00, 0, 1, 0, 0, 4);
        v(I_LW | I_BR | I_IHIT,                   5'b11111, 2'b11, 0, 1, 0, 0, 4);
        v(I_IHIT,                                 5'b11111, 2'b00, 0, 1, 0, 1, 4);
        // Wait counter restarts from zero after each MEM_WAIT exit
        v(I_RST,                    5'b00000, 2'b11, 0, 1, 0, 1, 4);
        v(I_DWEN | I_IHIT,          5'b00000, 2'b00, 0, 0, 0, 0, 0);
        v(I_DWEN | I_IHIT,          5'b00000, 2'b00, 0, 0, 0, 0, 1);
        v(I_DHIT | I_DWEN | I_IHIT, 5'b11111, 2'b00, 0, 0, 0, 0, 2);
        v(I_DWEN | I_IHIT,          5'b00000, 2'b00, 0, 0, 0, 0, 2);
        v(I_DWEN | I_IHIT,          5'b00000, 2'b00, 0, 0, 0, 0, 3);
        v(I_DHIT | I_DWEN | I_IHIT, 5'b11111, 2'b00, 0, 0, 0, 0, 4);
        v(I_IHIT,                   5'b11111, 2'b00, 0, 0, 0, 0, 4);
        // Long wait: cnt_memwait saturates at 15 with a 4-bit counter
        v(I_DREN | I_IHIT, 5'b00000, 2'b00, 0, 0, 0, 0, 4);
        for (int k = 1; k <= 14; k++) begin
            v(I_DREN | I_IHIT, 5'b00000, 2'b00, 0, (k >= 3) ? 1 : 0, 0, 0,
              (4 + k > 15) ? 15 : 4 + k);
        end
        v(I_DHIT | I_IHIT, 5'b11111, 2'b00, 0, 1, 0, 0, 15);
        // Halt: drain, then halted with all requests ignored
        v(I_HALT | I_IHIT,      5'b01111, 2'b11, 0, 1, 0, 0, 15);
        v(I_LW | I_BR | I_IHIT, 5'b00001, 2'b01, 0, 1, 0, 0, 15);
        v(I_LW | I_BR,          5'b00000, 2'b00, 1, 1, 0, 0, 15);
        v(I_DREN,               5'b00000, 2'b00, 1, 1, 0, 0, 15);
        v(I_LW | I_BR | I_IHIT, 5'b00000, 2'b00, 1, 1, 0, 0, 15);
        v(I_RST,                5'b00000, 2'b11, 1, 1, 0, 0, 15);
        v(I_IHIT,               5'b11111, 2'b00, 0, 0, 0, 0, 0);
        // Reset in the middle of MEM_WAIT
        v(I_DREN | I_IHIT, 5'b00000, 2'b00, 0, 0, 0, 0, 0);
        v(I_DREN,          5'b00000, 2'b00, 0, 0, 0, 0, 1);
        v(I_RST | I_DREN,  5'b00000, 2'b11, 0, 0, 0, 0, 2);
        v(I_IHIT,          5'b11111, 2'b00, 0, 0, 0, 0, 0);

        @(posedge CLK);
        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
